// File: rtl/frame_req_sequencer.sv
// Per-frame req/ack scheduler: on each frame tick it walks the enabled client
// channels in ascending order, repeating req/ack rounds until each one terminates.
module frame_req_sequencer #(
  parameter  int N_CH    = 4,
  parameter  int TIMEOUT = 200,
  parameter  int TO_W    = 8,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cal_frame,
  input  logic            i_game_start,
  input  logic [N_CH-1:0] i_ch_enable,
  output logic [N_CH-1:0] o_req,
  input  logic [N_CH-1:0] i_ack,
  input  logic [N_CH-1:0] i_frame_term,
  output logic [CH_W-1:0] o_cur_ch,
  output logic            o_busy,
  output logic            o_frame_done,
  output logic            o_timeout,
  output logic [CH_W-1:0] o_timeout_ch,
  output logic            o_overrun,
  output logic [15:0]     o_frame_cnt
);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, GAP, DONE} state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] pending_q, pending_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [CH_W-1:0] cur_ch_q, cur_ch_d;
  logic [N_CH-1:0] req_q, req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic [CH_W-1:0] timeout_ch_q, timeout_ch_d;
  logic            overrun_q, overrun_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [CH_W-1:0] lowest;
  logic            timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      to_cnt_q     <= '0;
      cur_ch_q     <= '0;
      req_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_ch_q <= '0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      to_cnt_q     <= to_cnt_d;
      cur_ch_q     <= cur_ch_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      timeout_ch_q <= timeout_ch_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Lowest pending channel wins, giving ascending service order.
  always_comb begin
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending_q[i]) lowest = CH_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    to_cnt_d    = to_cnt_q;
    cur_ch_d    = cur_ch_q;
    timeout_hit = 1'b0;
    if (i_game_start) begin
      state_d   = IDLE;
      pending_d = '0;
      to_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cal_frame) begin
            pending_d = i_ch_enable;
            to_cnt_d  = '0;
            state_d   = SCAN;
          end
        end
        SCAN: begin
          to_cnt_d = '0;
          if (pending_q == '0) begin
            state_d = DONE;
          end else begin
            cur_ch_d = lowest;
            state_d  = REQ;
          end
        end
        REQ: begin
          // An ack on the terminal count still counts as a response.
          if (i_ack[cur_ch_q]) begin
            to_cnt_d = '0;
            if (i_frame_term[cur_ch_q]) begin
              pending_d[cur_ch_q] = 1'b0;
              state_d             = SCAN;
            end else begin
              state_d = GAP;
            end
          end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            timeout_hit         = 1'b1;
            to_cnt_d            = '0;
            pending_d[cur_ch_q] = 1'b0;
            state_d             = SCAN;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        GAP:     state_d = REQ;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they appear registered in that state.
  always_comb begin
    req_d        = (state_d == REQ) ? (N_CH'(1) << cur_ch_d) : '0;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    timeout_d    = timeout_hit;
    timeout_ch_d = timeout_hit ? cur_ch_q : timeout_ch_q;
    overrun_d    = i_cal_frame && !i_game_start && (state_q != IDLE);
    frame_cnt_d  = frame_cnt_q;
    if (i_game_start)          frame_cnt_d = '0;
    else if (state_d == DONE)  frame_cnt_d = frame_cnt_q + 16'd1;
  end

  assign o_req        = req_q;
  assign o_cur_ch     = cur_ch_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_timeout    = timeout_q;
  assign o_timeout_ch = timeout_ch_q;
  assign o_overrun    = overrun_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: doc/frame_req_sequencer.md
Name: frame_req_sequencer

Overview:
- Parametrised per-frame handshake scheduler. It generalises the fixed platform/ball/brick req-ack ordering inside the collision block to N_CH client channels.
- On each i_cal_frame pulse it services every enabled channel in ascending index order. For each channel it repeats req/ack rounds until that channel signals frame termination.
- It adds per-channel timeout, frame-overrun detection and a frame counter. It sits between the frame-tick source and the game-object modules (platform, balls, gadgets, bricks).

Parameters:
N_CH, 4, number of client channels (2..16)
TIMEOUT, 200, max cycles o_req may stay high without ack before the channel is skipped (1..2**TO_W-1)
TO_W, 8, timeout counter width
CH_W, derived $clog2(N_CH), channel index width (local, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is synchronous and active-low
i_cal_frame  in  1  one-cycle frame-start pulse
i_game_start  in  1  abort/restart pulse
i_ch_enable  in  N_CH  channel participation mask, sampled at frame start
o_req  out  N_CH  one-hot request to the active channel
i_ack  in  N_CH  one-cycle ack per channel
i_frame_term  in  N_CH  qualifies ack: channel finished for this frame
o_cur_ch  out  CH_W  index of the channel being serviced
o_busy  out  1  high from the frame-start cycle+1 until DONE
o_frame_done  out  1  one-cycle pulse when all channels are serviced
o_timeout  out  1  one-cycle pulse on a channel timeout
o_timeout_ch  out  CH_W  index of the last timed-out channel (held)
o_overrun  out  1  one-cycle pulse when i_cal_frame arrives while busy
o_frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0; pending mask 0; timeout counter 0.
- States: IDLE, SCAN, REQ, GAP, DONE. All outputs are registered.
- IDLE:
  - On i_cal_frame, latch pending = i_ch_enable and go to SCAN.
  - If the latched mask is 0, SCAN goes straight to DONE.
- SCAN (1 cycle):
  - Select the lowest set bit of pending, set o_cur_ch to it, go to REQ.
  - If pending is 0, go to DONE.
- REQ:
  - o_req[o_cur_ch]=1, all other bits 0. Timeout counter increments each cycle.
  - On i_ack[o_cur_ch]=1: o_req drops the next cycle and the counter clears.
    - If i_frame_term[o_cur_ch] is also 1, clear that pending bit and go to SCAN.
    - Otherwise go to GAP.
  - If the counter reaches TIMEOUT with no ack:
    - Pulse o_timeout and set o_timeout_ch=o_cur_ch.
    - Clear the pending bit, drop o_req, go to SCAN.
  - Acks on channels other than o_cur_ch, and i_frame_term without ack, are ignored.
- GAP (1 cycle): o_req=0, then return to REQ on the same channel.
  - Guarantees a minimum 1-cycle low between consecutive requests.
- DONE (1 cycle):
  - Pulse o_frame_done, increment o_frame_cnt, go to IDLE.
  - o_busy is 0 in IDLE and high in SCAN, REQ, GAP and DONE.
- Overrun: i_cal_frame in any state other than IDLE pulses o_overrun the next cycle. The pulse is otherwise ignored and the current frame continues.
- i_game_start has priority over everything except reset:
  - From any state, the next state is IDLE; o_req and pending clear; o_frame_cnt=0; no o_frame_done.
  - i_cal_frame in the same cycle is ignored.
- Simultaneous ack and timeout-terminal cycle: ack wins; no timeout.
- Reset mid-frame: immediate return to the reset values at the next edge. Clients see o_req fall.
- Latency:
  - i_cal_frame at cycle t -> SCAN at t+1 -> first o_req high at t+2.
  - A single-round channel acked on its first request cycle costs 2 cycles (REQ + SCAN).

Test Plan:
- Basic frame: N_CH=4, enable=4'b1111, each channel acks with frame_term in its 1st REQ cycle -> o_req sequence 0001,0010,0100,1000; o_frame_done pulses once; o_frame_cnt=1.
- Multi-round: enable=4'b0010, channel 1 acks 3 times, frame_term only on the 3rd -> exactly 3 o_req high periods separated by 1-cycle GAPs; done after; o_timeout never set.
- Timeout: TIMEOUT=5, enable=4'b0101, channel 0 never acks -> o_req[0] high 5 cycles; o_timeout pulses with o_timeout_ch=0; channel 2 then serviced; o_frame_done pulses.
- Overrun and empty mask: i_cal_frame mid-frame -> o_overrun pulses 1 cycle and the frame completes normally. Separately, enable=0 -> o_frame_done 2 cycles after i_cal_frame with no o_req.
- Abort: i_game_start while in REQ on channel 2 after o_frame_cnt=7 -> next cycle o_req=0, o_busy=0, o_frame_cnt=0, no o_frame_done.
- Reset and wrap: preload 65535 frames (or force the count) and run one more -> o_frame_cnt=0. Pulse rst_n low for 1 cycle mid-REQ -> all outputs 0 on the next edge.
